// File: rtl/bip_control.sv
`default_nettype none
// ============================================================================
// Module      : bip_control
// Description : Control unit of the accumulator processor. Holds the program
//               counter, runs the IDLE/RUN/HALT sequencer and decodes the
//               fetched instruction into datapath strobes.
// Ports       : i_clk, i_rst_n       clock, asynchronous active-low reset
//               i_start              one-cycle pulse that leaves IDLE
//               i_instr              instruction at o_pc (combinational fetch)
//               o_pc, o_operand      program counter, operand field
//               o_sel_a, o_sel_b     accumulator source, ALU operand B source
//               o_op                 ALU op (0 add, 1 subtract)
//               o_wr_acc, o_rd_ram,
//               o_wr_ram             accumulator / data-memory enables
//               o_halt               high while halted
//               o_cycles             saturating count of RUN cycles
// Revision    : 1.0 - initial release
// ============================================================================
module bip_control #(
    parameter int I_BITS   = 16,
    parameter int OPC_BITS = 5,
    parameter int PC_BITS  = 11,
    parameter int S_BITS   = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [I_BITS-1:0]   i_instr,
    output logic [PC_BITS-1:0]  o_pc,
    output logic [PC_BITS-1:0]  o_operand,
    output logic [S_BITS-1:0]   o_sel_a,
    output logic                o_sel_b,
    output logic                o_op,
    output logic                o_wr_acc,
    output logic                o_rd_ram,
    output logic                o_wr_ram,
    output logic                o_halt,
    output logic [CNT_BITS-1:0] o_cycles
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HALT = 2'd2;

    localparam logic [OPC_BITS-1:0] c_OPC_HLT  = OPC_BITS'(0);
    localparam logic [OPC_BITS-1:0] c_OPC_STO  = OPC_BITS'(1);
    localparam logic [OPC_BITS-1:0] c_OPC_LD   = OPC_BITS'(2);
    localparam logic [OPC_BITS-1:0] c_OPC_LDI  = OPC_BITS'(3);
    localparam logic [OPC_BITS-1:0] c_OPC_ADD  = OPC_BITS'(4);
    localparam logic [OPC_BITS-1:0] c_OPC_ADDI = OPC_BITS'(5);
    localparam logic [OPC_BITS-1:0] c_OPC_SUB  = OPC_BITS'(6);
    localparam logic [OPC_BITS-1:0] c_OPC_SUBI = OPC_BITS'(7);

    localparam logic [S_BITS-1:0] c_SEL_RAM = S_BITS'(0);
    localparam logic [S_BITS-1:0] c_SEL_IMM = S_BITS'(1);
    localparam logic [S_BITS-1:0] c_SEL_ALU = S_BITS'(2);

    logic [1:0]          r_state_q,  w_state_d;
    logic [PC_BITS-1:0]  r_pc_q,     w_pc_d;
    logic [CNT_BITS-1:0] r_cycles_q, w_cycles_d;
    logic                r_halt_q,   w_halt_d;

    logic [OPC_BITS-1:0] w_opc;
    logic                w_run;

    assign w_opc = i_instr[I_BITS-1 -: OPC_BITS];
    assign w_run = (r_state_q == c_ST_RUN);

    // Next-state, PC and cycle-counter logic
    always_comb begin
        w_state_d  = r_state_q;
        w_pc_d     = r_pc_q;
        w_cycles_d = r_cycles_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (i_start) begin
                    w_state_d = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (r_cycles_q != {CNT_BITS{1'b1}}) begin
                    w_cycles_d = r_cycles_q + CNT_BITS'(1);
                end
                // HLT keeps the PC pointing at itself so the halt address is visible
                if (w_opc == c_OPC_HLT) begin
                    w_state_d = c_ST_HALT;
                end else begin
                    w_pc_d = r_pc_q + PC_BITS'(1);
                end
            end
            c_ST_HALT: begin
                w_state_d = c_ST_HALT;
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
        w_halt_d = (w_state_d == c_ST_HALT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q  <= c_ST_IDLE;
            r_pc_q     <= '0;
            r_cycles_q <= '0;
            r_halt_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_cycles_q <= w_cycles_d;
            r_halt_q   <= w_halt_d;
        end
    end

    // Instruction decode; every strobe is forced low outside RUN
    always_comb begin
        o_sel_a  = c_SEL_RAM;
        o_sel_b  = 1'b0;
        o_op     = 1'b0;
        o_wr_acc = 1'b0;
        o_rd_ram = 1'b0;
        o_wr_ram = 1'b0;
        if (w_run) begin
            case (w_opc)
                c_OPC_STO: begin
                    o_wr_ram = 1'b1;
                end
                c_OPC_LD: begin
                    o_rd_ram = 1'b1;
                    o_sel_a  = c_SEL_RAM;
                    o_wr_acc = 1'b1;
                end
                c_OPC_LDI: begin
                    o_sel_a  = c_SEL_IMM;
                    o_wr_acc = 1'b1;
                end
                c_OPC_ADD: begin
                    o_rd_ram = 1'b1;
                    o_sel_a  = c_SEL_ALU;
                    o_wr_acc = 1'b1;
                end
                c_OPC_ADDI: begin
                    o_sel_b  = 1'b1;
                    o_sel_a  = c_SEL_ALU;
                    o_wr_acc = 1'b1;
                end
                c_OPC_SUB: begin
                    o_rd_ram = 1'b1;
                    o_op     = 1'b1;
                    o_sel_a  = c_SEL_ALU;
                    o_wr_acc = 1'b1;
                end
                c_OPC_SUBI: begin
                    o_sel_b  = 1'b1;
                    o_op     = 1'b1;
                    o_sel_a  = c_SEL_ALU;
                    o_wr_acc = 1'b1;
                end
                default: begin
                    // HLT and the unused opcodes (NOP) leave every strobe low
                end
            endcase
        end
    end

    assign o_pc      = r_pc_q;
    assign o_operand = i_instr[PC_BITS-1:0];
    assign o_halt    = r_halt_q;
    assign o_cycles  = r_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_bip_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_bip_control
// Description : Self-checking bench for bip_control. A reference model of the
//               sequencer produces the expected outputs of each cycle into a
//               scoreboard queue; the entries are popped and compared against
//               the DUT mid-cycle. A second instance with a 4-bit counter
//               exercises counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_control;

    localparam logic [1:0] c_M_IDLE = 2'd0;
    localparam logic [1:0] c_M_RUN  = 2'd1;
    localparam logic [1:0] c_M_HALT = 2'd2;
    localparam logic [4:0] c_NOP    = 5'b01000;

    typedef struct packed {
        logic [10:0] pc;
        logic [10:0] operand;
        logic [6:0]  strb;
        logic        halt;
        logic [15:0] cyc;
        logic [3:0]  cyc4;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [15:0] instr;
    logic [15:0] mem [0:2047];

    logic [10:0] pc, operand;
    logic [1:0]  sel_a;
    logic        sel_b, op, wr_acc, rd_ram, wr_ram, halt;
    logic [15:0] cycles;

    logic [10:0] pc2, operand2;
    logic [1:0]  sel_a2;
    logic        sel_b2, op2, wr_acc2, rd_ram2, wr_ram2, halt2;
    logic [3:0]  cycles2;

    exp_t        sb [$];
    int          n_checks;
    int          n_fail;

    logic [1:0]  m_state;
    logic [10:0] m_pc;
    logic [15:0] m_cyc;

    assign instr = mem[pc];

    bip_control u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (i_start),
        .i_instr   (instr),
        .o_pc      (pc),
        .o_operand (operand),
        .o_sel_a   (sel_a),
        .o_sel_b   (sel_b),
        .o_op      (op),
        .o_wr_acc  (wr_acc),
        .o_rd_ram  (rd_ram),
        .o_wr_ram  (wr_ram),
        .o_halt    (halt),
        .o_cycles  (cycles)
    );

    bip_control #(.CNT_BITS(4)) u_dut4 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (i_start),
        .i_instr   (instr),
        .o_pc      (pc2),
        .o_operand (operand2),
        .o_sel_a   (sel_a2),
        .o_sel_b   (sel_b2),
        .o_op      (op2),
        .o_wr_acc  (wr_acc2),
        .o_rd_ram  (rd_ram2),
        .o_wr_ram  (wr_ram2),
        .o_halt    (halt2),
        .o_cycles  (cycles2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected strobes packed as {sel_a[1:0], sel_b, op, wr_acc, rd_ram, wr_ram}
    function automatic logic [6:0] exp_strb(input logic [1:0] st, input logic [4:0] opc);
        if (st != c_M_RUN) return 7'b0;
        case (opc)
            5'd1:    return 7'b00_0_0_0_0_1; // STO
            5'd2:    return 7'b00_0_0_1_1_0; // LD
            5'd3:    return 7'b01_0_0_1_0_0; // LDI
            5'd4:    return 7'b10_0_0_1_1_0; // ADD
            5'd5:    return 7'b10_1_0_1_0_0; // ADDI
            5'd6:    return 7'b10_0_1_1_1_0; // SUB
            5'd7:    return 7'b10_1_1_1_0_0; // SUBI
            default: return 7'b0;            // HLT, NOP
        endcase
    endfunction

    task automatic push_expected();
        exp_t e;
        e.pc      = m_pc;
        e.operand = mem[m_pc][10:0];
        e.strb    = exp_strb(m_state, mem[m_pc][15:11]);
        e.halt    = (m_state == c_M_HALT);
        e.cyc     = m_cyc;
        e.cyc4    = (m_cyc > 16'd15) ? 4'hf : m_cyc[3:0];
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("pc",       {21'd0, pc},      {21'd0, e.pc});
        check("operand",  {21'd0, operand}, {21'd0, e.operand});
        check("strobes",  {25'd0, sel_a, sel_b, op, wr_acc, rd_ram, wr_ram}, {25'd0, e.strb});
        check("halt",     {31'd0, halt},    {31'd0, e.halt});
        check("cycles",   {16'd0, cycles},  {16'd0, e.cyc});
        check("cycles4",  {28'd0, cycles2}, {28'd0, e.cyc4});
        check("pc_inst4", {21'd0, pc2},     {21'd0, e.pc});
    endtask

    // One clock cycle: record the expectation, compare at the falling edge,
    // then advance the model across the rising edge.
    task automatic cycle(input logic start);
        logic [4:0] opc;
        i_start = start;
        push_expected();
        @(negedge clk);
        compare_front();
        opc = mem[m_pc][15:11];
        @(posedge clk);
        case (m_state)
            c_M_IDLE: if (start) m_state = c_M_RUN;
            c_M_RUN: begin
                if (m_cyc != 16'hffff) m_cyc = m_cyc + 16'd1;
                if (opc == 5'd0) m_state = c_M_HALT;
                else             m_pc    = m_pc + 11'd1;
            end
            default: ;
        endcase
        #1;
    endtask

    // Asynchronous reset: checked before any clock edge, then released
    task automatic do_reset();
        rst_n   = 1'b0;
        m_state = c_M_IDLE;
        m_pc    = '0;
        m_cyc   = '0;
        #1;
        push_expected();
        compare_front();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 2048; i++) mem[i] = {c_NOP, 11'(i)};
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_start  = 1'b0;
        rst_n    = 1'b0;
        fill_nop();
        m_state = c_M_IDLE;
        m_pc    = '0;
        m_cyc   = '0;

        // Reset state and idle behaviour
        do_reset();
        cycle(1'b0);
        cycle(1'b0);

        // Decode sweep with extra start pulses in RUN, then HALT hold
        mem[0] = {5'd3, 11'd3};
        mem[1] = {5'd5, 11'd4};
        mem[2] = {5'd7, 11'd1};
        mem[3] = {5'd1, 11'd7};
        mem[4] = {5'd2, 11'd7};
        mem[5] = {5'd4, 11'd7};
        mem[6] = {5'd6, 11'd7};
        mem[7] = {5'd0, 11'd0};
        cycle(1'b1);
        for (int i = 0; i < 9; i++) cycle(i % 3 == 1);
        for (int i = 0; i < 20; i++) cycle(1'b1);
        check("halt_pc",     {21'd0, pc},     32'd7);
        check("halt_cycles", {16'd0, cycles}, 32'd8);
        check("halt_flag",   {31'd0, halt},   32'd1);

        // Illegal opcode at pc=2, then asynchronous reset mid-RUN at pc=5
        do_reset();
        fill_nop();
        mem[2] = {5'b11111, 11'h2aa};
        cycle(1'b1);
        for (int i = 0; i < 20 && m_pc != 11'd5; i++) cycle(1'b0);
        check("reached_pc5", {21'd0, pc}, 32'd5);
        #2;
        do_reset();
        check("rst_pc",     {21'd0, pc},     32'd0);
        check("rst_cycles", {16'd0, cycles}, 32'd0);

        // All-NOP program: PC wrap and 4-bit counter saturation
        fill_nop();
        cycle(1'b1);
        for (int i = 0; i < 2060; i++) cycle(1'b0);
        check("wrap_cycles4", {28'd0, cycles2}, 32'd15);

        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
